// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel interval timer: mode encoding and
// the default prescale for the 50 MHz board clock.
package timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // 50000 cycles of 50 MHz gives a 1 ms base tick
  localparam int DEFAULT_PRESCALE = 50000;

endpackage

// File: rtl/timer_multi_rc_if.sv
// Control/status bundle of the multi-channel timer; the timer takes the slave
// side, whoever programs the channels takes the master side.
interface timer_multi_rc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 10
);

  logic [NUM_CH-1:0]       Start;
  logic [NUM_CH-1:0]       Stop;
  logic [NUM_CH-1:0]       Clear;
  logic [NUM_CH-1:0]       Mode;
  logic [NUM_CH*CNT_W-1:0] CfgValue;
  logic [NUM_CH-1:0]       Tick;
  logic [NUM_CH-1:0]       Running;
  logic [NUM_CH*CNT_W-1:0] Count;
  logic                    BaseTick;

  modport master (
    output Start, Stop, Clear, Mode, CfgValue,
    input  Tick, Running, Count, BaseTick
  );

  modport slave (
    input  Start, Stop, Clear, Mode, CfgValue,
    output Tick, Running, Count, BaseTick
  );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running divider producing a one-cycle base-tick strobe every PRESCALE
// clocks; one instance feeds every timer channel.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic Clk,
  input  logic Rst,
  output logic BaseTick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic          run;

  // run masks the strobe while in reset, which matters only when PRESCALE=1
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign BaseTick = run && (cnt == LAST);

endmodule

// File: rtl/timer_multi_rc.sv
// N-channel reconfigurable interval timer: one shared prescaler, each channel
// counts base ticks up to its own latched period in periodic or one-shot mode.
module timer_multi_rc
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 10,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             Clk,
  input  logic             Rst,
  timer_multi_rc_if.slave  bus
);

  logic base_tick;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .Clk      (Clk),
    .Rst      (Rst),
    .BaseTick (base_tick)
  );

  assign bus.BaseTick = base_tick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cfg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period;
    logic             mode;
    logic             running;
    logic             tick;
    logic             expire;

    assign cfg    = bus.CfgValue[i*CNT_W +: CNT_W];
    assign expire = (count == period - CNT_W'(1));

    // Clear beats Start beats Stop beats the base tick; a zero period is held as 1
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        count   <= '0;
        period  <= '0;
        mode    <= MODE_PERIODIC;
        running <= 1'b0;
        tick    <= 1'b0;
      end else begin
        tick <= 1'b0;
        if (bus.Clear[i]) begin
          count   <= '0;
          running <= 1'b0;
        end else if (bus.Start[i]) begin
          count   <= '0;
          running <= 1'b1;
          period  <= (cfg == '0) ? CNT_W'(1) : cfg;
          mode    <= bus.Mode[i];
        end else if (bus.Stop[i]) begin
          running <= 1'b0;
        end else if (base_tick && running) begin
          if (expire) begin
            count <= '0;
            tick  <= 1'b1;
            if (mode == MODE_ONESHOT) begin
              running <= 1'b0;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      end
    end

    assign bus.Tick[i]                   = tick;
    assign bus.Running[i]                = running;
    assign bus.Count[i*CNT_W +: CNT_W]   = count;
  end

endmodule

// File: tb/tb_timer_multi_rc.sv
// Directed bench for timer_multi_rc with PRESCALE=4, expectations worked out by hand.
module tb_timer_multi_rc;
  import timer_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 10;
  localparam int PRESCALE = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  timer_multi_rc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  timer_multi_rc #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic int countOf(input int ch);
    return int'(bus.Count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic setCfg(input int ch, input logic [CNT_W-1:0] v);
    bus.CfgValue[ch*CNT_W +: CNT_W] = v;
  endtask

  // Start a channel on the edge that consumes a BaseTick, so the prescaler
  // phase is known: that edge is E0 and the next base ticks land on E4, E8, ...
  task automatic applyStimulus(input int ch, input logic mode, input logic [CNT_W-1:0] cfg);
    int guard = 0;
    while (bus.BaseTick !== 1'b1 && guard < 2 * PRESCALE) begin
      step(1);
      guard++;
    end
    checkOutput("align_basetick", 32'(bus.BaseTick), 1);
    bus.Mode[ch] = mode;
    setCfg(ch, cfg);
    bus.Start[ch] = 1'b1;
    step(1);
    bus.Start[ch] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int extra;
    int peak;

    bus.Start    = '0;
    bus.Stop     = '0;
    bus.Clear    = '0;
    bus.Mode     = '0;
    bus.CfgValue = '0;

    Rst = 1'b0;
    step(2);
    checkOutput("rst_tick",     32'(bus.Tick), 0);
    checkOutput("rst_running",  32'(bus.Running), 0);
    checkOutput("rst_count",    32'(bus.Count == '0), 1);
    checkOutput("rst_basetick", 32'(bus.BaseTick), 0);

    Rst = 1'b1;
    step(2);
    checkOutput("presc_early", 32'(bus.BaseTick), 0);
    step(1);
    checkOutput("presc_first", 32'(bus.BaseTick), 1);
    step(1);
    checkOutput("presc_single", 32'(bus.BaseTick), 0);

    $display("[TB] periodic channel 0, period 3");
    applyStimulus(0, MODE_PERIODIC, 3);
    checkOutput("per_running0", 32'(bus.Running[0]), 1);
    checkOutput("per_count0",   countOf(0), 0);
    step(4);
    checkOutput("per_count_e4", countOf(0), 1);
    step(7);
    checkOutput("per_tick_e11",  32'(bus.Tick[0]), 0);
    checkOutput("per_count_e11", countOf(0), 2);
    step(1);
    checkOutput("per_tick_e12",    32'(bus.Tick[0]), 1);
    checkOutput("per_count_e12",   countOf(0), 0);
    checkOutput("per_running_e12", 32'(bus.Running[0]), 1);
    step(1);
    checkOutput("per_tick_e13", 32'(bus.Tick[0]), 0);

    setCfg(0, 7);
    step(11);
    checkOutput("latch_tick_e24", 32'(bus.Tick[0]), 1);
    step(12);
    checkOutput("latch_tick_e36", 32'(bus.Tick[0]), 1);

    applyStimulus(0, MODE_PERIODIC, 7);
    step(12);
    checkOutput("latch_new_e12", 32'(bus.Tick[0]), 0);
    step(15);
    checkOutput("latch_new_e27", 32'(bus.Tick[0]), 0);
    step(1);
    checkOutput("latch_new_e28", 32'(bus.Tick[0]), 1);

    $display("[TB] one-shot channel 1, period 2");
    applyStimulus(1, MODE_ONESHOT, 2);
    step(7);
    checkOutput("os_running_e7", 32'(bus.Running[1]), 1);
    checkOutput("os_tick_e7",    32'(bus.Tick[1]), 0);
    step(1);
    checkOutput("os_tick_e8",    32'(bus.Tick[1]), 1);
    checkOutput("os_running_e8", 32'(bus.Running[1]), 0);
    extra = 0;
    repeat (100) begin
      step(1);
      extra += int'(bus.Tick[1]);
    end
    checkOutput("os_no_more_ticks", extra, 0);

    $display("[TB] channel 2 with period 0");
    applyStimulus(2, MODE_PERIODIC, 0);
    step(4);
    checkOutput("zero_tick_e4", 32'(bus.Tick[2]), 1);
    step(1);
    checkOutput("zero_tick_e5", 32'(bus.Tick[2]), 0);
    step(3);
    checkOutput("zero_tick_e8",  32'(bus.Tick[2]), 1);
    checkOutput("zero_count_e8", countOf(2), 0);

    bus.Clear[2] = 1'b1;
    bus.Start[2] = 1'b1;
    step(1);
    bus.Clear[2] = 1'b0;
    bus.Start[2] = 1'b0;
    checkOutput("clr_start_running", 32'(bus.Running[2]), 0);
    checkOutput("clr_start_count",   countOf(2), 0);

    $display("[TB] channel 3 with maximum period 1023");
    applyStimulus(3, MODE_PERIODIC, 1023);
    peak = 0;
    repeat (4091) begin
      step(1);
      if (countOf(3) > peak) peak = countOf(3);
    end
    checkOutput("max_tick_pre",  32'(bus.Tick[3]), 0);
    checkOutput("max_count_pre", countOf(3), 1022);
    checkOutput("max_peak",      peak, 1022);
    step(1);
    checkOutput("max_tick",    32'(bus.Tick[3]), 1);
    checkOutput("max_count",   countOf(3), 0);
    checkOutput("max_running", 32'(bus.Running[3]), 1);

    $display("[TB] stop and restart on channel 3");
    applyStimulus(3, MODE_PERIODIC, 20);
    step(20);
    checkOutput("stop_count_e20", countOf(3), 5);
    bus.Stop[3] = 1'b1;
    step(1);
    bus.Stop[3] = 1'b0;
    checkOutput("stop_running", 32'(bus.Running[3]), 0);
    extra = 0;
    repeat (40) begin
      step(1);
      extra += int'(bus.Tick[3]);
    end
    checkOutput("stop_hold_count", countOf(3), 5);
    checkOutput("stop_no_tick",    extra, 0);
    bus.Start[3] = 1'b1;
    step(1);
    bus.Start[3] = 1'b0;
    checkOutput("restart_count",   countOf(3), 0);
    checkOutput("restart_running", 32'(bus.Running[3]), 1);

    $display("[TB] reset while channels run");
    Rst = 1'b0;
    step(1);
    checkOutput("mid_rst_tick",     32'(bus.Tick), 0);
    checkOutput("mid_rst_running",  32'(bus.Running), 0);
    checkOutput("mid_rst_count",    32'(bus.Count == '0), 1);
    checkOutput("mid_rst_basetick", 32'(bus.BaseTick), 0);
    Rst = 1'b1;
    step(2);
    checkOutput("mid_presc_early", 32'(bus.BaseTick), 0);
    step(1);
    checkOutput("mid_presc_first", 32'(bus.BaseTick), 1);
    checkOutput("mid_running_after", 32'(bus.Running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_multi_rc.md
Name: timer_multi_rc

Overview:
- N-channel reconfigurable interval timer; successor to the single-channel fixed-width timer.
- One shared prescaler produces a base-tick strobe. Each channel counts base ticks up to its own latched period and emits a 1-cycle Tick.
- Per-channel periodic or one-shot mode, start/stop/clear control, running-status and count readback.
- Feeds game-speed, display-blink and debounce logic.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 10, width of each channel period/count
PRESCALE, 50000, Clk cycles per base tick (1 ms at 50 MHz); must be >= 1

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-low reset
Start  in  NUM_CH  per-channel start/restart pulse
Stop  in  NUM_CH  per-channel pause (hold count)
Clear  in  NUM_CH  per-channel clear to idle
Mode  in  NUM_CH  0 = periodic, 1 = one-shot; sampled at Start
CfgValue  in  NUM_CH*CNT_W  per-channel period in base ticks; channel i at bits [i*CNT_W +: CNT_W]
Tick  out  NUM_CH  1-cycle expiry pulse per channel
Running  out  NUM_CH  channel active
Count  out  NUM_CH*CNT_W  current count per channel, same packing as CfgValue
BaseTick  out  1  prescaler strobe, for bench alignment and sharing

Behaviour:
- Reset (Rst=0 at a posedge): Tick=0, Running=0, all Count=0, latched periods=0, prescaler count=0, BaseTick=0.
- Prescaler: free-runs whenever Rst=1; counter 0..PRESCALE-1. BaseTick=1 for exactly one cycle when the counter equals PRESCALE-1, then the counter wraps to 0. PRESCALE=1 gives BaseTick constantly high.
- Per-channel priority at each posedge (highest first): Rst > Clear > Start > Stop > BaseTick.
- Clear: Count=0, Running=0, Tick=0.
- Start:
  - Count=0, Running=1.
  - Period latched from CfgValue and mode latched from Mode.
  - A value of 0 is latched as 1.
  - Start while already running restarts the channel. BaseTick in the same cycle is ignored.
- Stop: Running=0, Count held. A later Start restarts from 0; there is no resume-from-count.
- BaseTick while Running=1:
  - If Count == Period-1: Count=0 and Tick=1 on that edge.
  - If mode is periodic, Running stays 1.
  - If mode is one-shot, Running=0 on the same edge.
  - Otherwise Count=Count+1.
- Tick is registered and high for exactly 1 Clk cycle, in the cycle following the BaseTick cycle. Tick is 0 in all other cycles.
- Period N gives expiry every N base ticks (N*PRESCALE clocks). Maximum period 2^CNT_W-1. Count never exceeds Period-1, so no wrap-around.
- CfgValue changes while running have no effect until the next Start.
- Channels are fully independent; simultaneous events on different channels never interact.

Decomposition:
- Shared package (timer_pkg): mode encoding constants (MODE_PERIODIC=0, MODE_ONESHOT=1) and default PRESCALE for the board clock.
- Sub-module timer_prescaler (parameter PRESCALE; Clk, Rst, BaseTick): one instance, shared by all channels.
- Channels are built with a generate loop over NUM_CH within the top module; no per-channel sub-module.

Test Plan:
- Bench parameters: NUM_CH=4, CNT_W=10, PRESCALE=4.
- Periodic: ch0 Start, Mode=0, CfgValue=3 -> Tick[0] pulses 1 cycle every 12 Clk, first pulse 3 BaseTicks after Start; Running[0] stays 1.
- One-shot: ch1 Mode=1, CfgValue=2 -> exactly one Tick[1] after 2 BaseTicks; Running[1] falls on the same edge Tick rises; no further Ticks over 100 cycles.
- Boundary: ch2 CfgValue=0 -> treated as 1, Tick[2] on every BaseTick. CfgValue=1023 -> Tick after 1023 BaseTicks, Count peaks at 1022.
- Control priority:
  - Clear and Start asserted in the same cycle -> Running=0, Count=0.
  - Stop at Count=5 -> Count holds at 5 across 10 BaseTicks, no Tick.
  - Start then -> Count=0.
- Latching: change CfgValue 3->7 mid-run -> period stays 3 until the next Start, then 7.
- Reset mid-run with Rst=0 for one cycle -> all outputs 0 next cycle, prescaler restarts (first BaseTick 4 cycles after release).
